// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  localparam int XLEN           = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - little-endian byte-to-word assembler for the loader
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            beat,
  input  logic [7:0]      byte_in,
  output logic [XLEN-1:0] word_next,
  output logic            word_full
);

  logic [1:0]      byte_idx;
  logic [XLEN-1:0] word;

  // Word as it will look once the current byte lands in its lane; the FSM
  // captures this directly on the final beat so WRITE needs no extra cycle.
  always_comb begin
    word_next = word;
    word_next[{byte_idx, 3'b000} +: 8] = byte_in;
    word_full = beat && (byte_idx == 2'(BYTES_PER_WORD - 1));
  end

  // Lane index and partial word; the 2-bit index wraps to 0 after the 4th byte.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (beat) begin
      word     <= word_next;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to instruction memory write master with core hold
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int BASE_ADDR = 1,
  parameter int CNT_W     = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [XLEN-1:0]  WriteReg,
  output logic [XLEN-1:0]  WriteData,
  output logic             RegWrite,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Word 0 holds the reset NOP, so at most DEPTH-BASE_ADDR words fit.
  localparam logic [CNT_W-1:0] MAX_WORDS  = CNT_W'(DEPTH - BASE_ADDR);
  localparam logic [CNT_W-1:0] FIRST_ADDR = CNT_W'(BASE_ADDR);

  state_t           state;
  logic [CNT_W-1:0] addr;
  logic [CNT_W-1:0] remaining;
  logic             beat;
  logic             pk_clear;
  logic             word_full;
  logic [XLEN-1:0]  word_next;

  assign byte_ready = (state == COLLECT);
  assign beat       = byte_valid && byte_ready;
  assign pk_clear   = (state == IDLE) || (state == WRITE);

  imem_word_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (pk_clear),
    .beat      (beat),
    .byte_in   (byte_in),
    .word_next (word_next),
    .word_full (word_full)
  );

  // Load sequencer: count check, word collection, one write strobe per word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      WriteReg  <= '0;
      WriteData <= '0;
      RegWrite  <= 1'b0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count == '0 || word_count > MAX_WORDS) begin
              err <= 1'b1;
            end else begin
              remaining <= word_count;
              addr      <= FIRST_ADDR;
              cpu_hold  <= 1'b1;
              busy      <= 1'b1;
              state     <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (word_full) begin
            RegWrite  <= 1'b1;
            WriteReg  <= {{(XLEN - CNT_W){1'b0}}, addr};
            WriteData <= word_next;
            state     <= WRITE;
          end
        end
        WRITE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= COLLECT;
          end
        end
        DONE: begin
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with randomized byte streams
module tb_imem_loader;

  localparam int DEPTH     = 32;
  localparam int BASE_ADDR = 1;
  localparam int CNT_W     = 6;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic             clock;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [31:0]      WriteReg;
  logic [31:0]      WriteData;
  logic             RegWrite;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks_total = 0;
  int checks_passed = 0;
  int write_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] last_addr = '0;
  logic prev_done = 1'b0;
  wr_t exp_q[$];
  logic [7:0] stim_bytes[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (!reset) begin
      if (RegWrite) begin
        write_cnt++;
        last_addr = WriteReg;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", WriteReg, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", WriteReg, e.addr);
          chk("write_data", WriteData, e.data);
          chk("hold_during_write", {31'b0, cpu_hold}, 32'd1);
        end
      end
      if (done) begin
        done_cnt++;
        chk("hold_at_done", {31'b0, cpu_hold}, 32'd1);
      end
      if (prev_done) chk("hold_after_done", {31'b0, cpu_hold}, 32'd0);
      if (err) begin
        err_cnt++;
        chk("hold_at_err", {31'b0, cpu_hold}, 32'd0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic start_load(input int n);
    word_count = CNT_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    byte_in = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      acc = byte_ready;
      step();
      if (acc) return;
    end
    chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Reference: word i is bytes 4i..4i+3, least significant first, at BASE_ADDR+i.
  task automatic push_expected(input int w);
    wr_t e;
    e.addr = 32'(BASE_ADDR + w);
    e.data = 32'(stim_bytes[4*w]) + (32'(stim_bytes[4*w+1]) << 8)
           + (32'(stim_bytes[4*w+2]) << 16) + (32'(stim_bytes[4*w+3]) << 24);
    exp_q.push_back(e);
  endtask

  task automatic finish_load(input int n, input int w0, input int d0);
    int k;
    byte_valid = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 40) begin
      step();
      k++;
    end
    step();
    step();
    chk("done_count", 32'(done_cnt), 32'(d0 + 1));
    chk("write_count", 32'(write_cnt), 32'(w0 + n));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_random(input int n);
    stim_bytes.delete();
    for (int i = 0; i < 4 * n; i++) stim_bytes.push_back(8'($urandom));
  endtask

  task automatic run_load(input int n, input int gap_pct);
    int w0, d0;
    w0 = write_cnt;
    d0 = done_cnt;
    start_load(n);
    for (int w = 0; w < n; w++) begin
      push_expected(w);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(99) < gap_pct) idle($urandom_range(3, 1));
        send_byte(stim_bytes[4*w+b]);
      end
    end
    finish_load(n, w0, d0);
  endtask

  task automatic illegal_start(input int n);
    int w0, e0;
    w0 = write_cnt;
    e0 = err_cnt;
    start_load(n);
    step();
    step();
    chk("err_count", 32'(err_cnt), 32'(e0 + 1));
    chk("err_one_cycle", {31'b0, err}, 32'd0);
    chk("err_hold_low", {31'b0, cpu_hold}, 32'd0);
    chk("err_no_write", 32'(write_cnt), 32'(w0));
  endtask

  initial begin
    int w0, d0;
    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    repeat (3) step();
    chk("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("rst_writereg", WriteReg, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    chk("rst_hold", {31'b0, cpu_hold}, 32'd0);
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    reset = 1'b0;
    step();

    // Nominal three-word program
    stim_bytes = '{8'hB3, 8'h00, 8'h20, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h40,
                   8'hB3, 8'hE0, 8'h62, 8'h00};
    run_load(3, 0);
    chk("nominal_last_addr", last_addr, 32'd3);

    // Back-pressure: valid pattern 1,0,0,1,1,0,1
    fill_random(1);
    w0 = write_cnt;
    d0 = done_cnt;
    start_load(1);
    push_expected(0);
    send_byte(stim_bytes[0]);
    idle(2);
    send_byte(stim_bytes[1]);
    send_byte(stim_bytes[2]);
    idle(1);
    send_byte(stim_bytes[3]);
    finish_load(1, w0, d0);

    // Illegal counts, including the first value past the limit
    illegal_start(0);
    illegal_start(DEPTH - BASE_ADDR + 1);

    // Start during COLLECT is ignored
    fill_random(3);
    w0 = write_cnt;
    d0 = done_cnt;
    start_load(3);
    push_expected(0);
    send_byte(stim_bytes[0]);
    send_byte(stim_bytes[1]);
    byte_valid = 1'b0;
    start_load(7);
    send_byte(stim_bytes[2]);
    send_byte(stim_bytes[3]);
    for (int w = 1; w < 3; w++) begin
      push_expected(w);
      for (int b = 0; b < 4; b++) send_byte(stim_bytes[4*w+b]);
    end
    finish_load(3, w0, d0);

    // Reset after two bytes of word 2
    fill_random(3);
    w0 = write_cnt;
    start_load(3);
    push_expected(0);
    for (int b = 0; b < 4; b++) send_byte(stim_bytes[b]);
    send_byte(stim_bytes[4]);
    send_byte(stim_bytes[5]);
    byte_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("midrst_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("midrst_writereg", WriteReg, 32'd0);
    chk("midrst_writedata", WriteData, 32'd0);
    chk("midrst_hold", {31'b0, cpu_hold}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done_err", {30'b0, done, err}, 32'd0);
    chk("midrst_ready", {31'b0, byte_ready}, 32'd0);
    reset = 1'b0;
    idle(6);
    chk("midrst_writes", 32'(write_cnt), 32'(w0 + 1));
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    fill_random(1);
    run_load(1, 0);
    chk("fresh_load_addr", last_addr, 32'(BASE_ADDR));

    // Full fill up to the top word
    fill_random(DEPTH - BASE_ADDR);
    run_load(DEPTH - BASE_ADDR, 0);
    chk("full_last_addr", last_addr, 32'(DEPTH - 1));

    // Random loads with random stalls
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(8, 1);
      fill_random(n);
      run_load(n, 30);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side master for the instruction memory. It accepts a byte stream with a valid/ready handshake and assembles bytes into 32-bit little-endian instruction words.
- It drives the memory's WriteReg/WriteData/RegWrite port with one single-cycle write per word, at consecutive word addresses.
- While a load is in progress it asserts cpu_hold, which keeps the unicycle core stalled until the program image is in place.

Parameters:
- DEPTH, 32, number of 32-bit words in the instruction memory.
- BASE_ADDR, 1, word address of the first written word (word 0 is kept as the reset NOP).
- CNT_W, 6, width of word_count; must hold the value DEPTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  input  CNT_W  number of words to load; sampled together with start.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- WriteReg  output  32  word address to the instruction memory.
- WriteData  output  32  assembled instruction word.
- RegWrite  output  1  write strobe to the instruction memory, one cycle per word.
- cpu_hold  output  1  stalls the core while a load is active.
- busy  output  1  high in COLLECT and WRITE.
- done  output  1  one-cycle pulse when the last word has been written.
- err  output  1  one-cycle pulse when start carries an illegal word_count.

Behaviour:
- Reset (sync, active-high) clears all state and outputs to 0; state goes to IDLE.
- Reset mid-load discards any partial word; no RegWrite is issued in the reset cycle or after it.
- Outputs are registered except byte_ready, which is decoded combinationally from state: 1 only in COLLECT.
- IDLE:
  - byte_ready=0, cpu_hold=0.
  - On start with 1 <= word_count <= DEPTH-BASE_ADDR: latch the count into a remaining counter, set addr=BASE_ADDR, clear byte_idx and the shift register, go to COLLECT.
  - On start with word_count=0 or word_count > DEPTH-BASE_ADDR: err=1 for the next cycle, stay in IDLE.
- COLLECT:
  - cpu_hold=1, busy=1.
  - A beat is byte_valid && byte_ready. Each beat places byte_in at bits [8*byte_idx+7 : 8*byte_idx] (little-endian), then byte_idx increments.
  - byte_valid low stalls indefinitely; there is no timeout.
  - The 4th beat (byte_idx=3) moves the FSM to WRITE.
- WRITE (exactly one cycle):
  - RegWrite=1, WriteReg=addr (zero-extended to 32 bits), WriteData=assembled word, byte_ready=0.
  - On exit: addr increments, remaining decrements, byte_idx returns to 0.
  - If remaining was 1, go to DONE; otherwise go to COLLECT.
- DONE (one cycle):
  - done=1, cpu_hold=1; next state is IDLE.
  - cpu_hold falls in the cycle after done.
- start is ignored in every state other than IDLE.
- WriteReg and WriteData hold their last values when RegWrite=0.
- Latency: the write strobe occurs the cycle after the 4th beat. Best-case throughput is one word per 5 cycles.
- addr never exceeds DEPTH-1, guaranteed by the word_count check; there is no wrap-around.

Decomposition:
- Shared package holds:
  - The FSM state encoding: IDLE=2'd0, COLLECT=2'd1, WRITE=2'd2, DONE=2'd3.
  - XLEN=32 and BYTES_PER_WORD=4.
- One natural sub-module is imem_word_packer: the byte_idx counter plus the 32-bit little-endian shift register, with a word_full flag. The FSM, address counter and remaining counter stay at top level.

Test Plan:
- Nominal load:
  - Stimulus: start, word_count=3, bytes B3 00 20 00 | B3 00 31 40 | B3 E0 62 00 with valid held high.
  - Required writes: RegWrite at addresses 1, 2, 3 with data 0x002000B3, 0x403100B3, 0x0062E0B3.
  - Then done pulses once and cpu_hold falls the cycle after.
- Back-pressure:
  - Stimulus: valid toggles 1,0,0,1,1,0,1 across the 4 bytes of one word.
  - Required: the word is still assembled correctly, and exactly one RegWrite occurs.
- Illegal count:
  - Stimulus: start with word_count=0, then start with word_count=32 (BASE_ADDR=1).
  - Required: err pulses each time, cpu_hold stays 0, no RegWrite.
- Start while busy:
  - Stimulus: start pulse during COLLECT with a different word_count.
  - Required: ignored, and the original count of writes completes.
- Reset mid-word:
  - Stimulus: assert reset after 2 bytes of word 2.
  - Required: all outputs 0 the next cycle and no write of word 2.
  - Then a fresh load of 1 word writes to address 1.
- Full fill:
  - Stimulus: word_count=31.
  - Required: last write at WriteReg=31, exactly 31 RegWrite strobes, one done.
